bus_cond_detector: RTL and testbench

BUS_COND_DETECTOR -- requirements
Module: bus_cond_detector

---
 rtl/bus_cond_detector.sv | 228 ++++++++++++++++++++++
 tb/tb_bus_cond_detector.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cond_detector.sv
// -----------------------------------------------------------------------------
// bus_cond_detector
// Conditions the raw SCL/SDA pad inputs and detects bus conditions on them.
// Each line is synchronized and then glitch-filtered. Registered edge pulses
// and START/STOP pulses are derived from the filtered lines. When i_hdr_en is
// high, an FSM tracks the HDR Restart and HDR Exit patterns.
//
// Ports
//   i_sys_clk       system clock, all state on the rising edge
//   i_sys_rst       asynchronous active-high reset
//   i_scl, i_sda    raw pad levels, asynchronous to i_sys_clk
//   i_hdr_en        target is in HDR mode (enables the pattern FSM)
//   o_scl, o_sda    filtered line levels
//   o_scl_pos/neg   one-cycle edge pulses of filtered SCL
//   o_sda_pos/neg   one-cycle edge pulses of filtered SDA
//   o_start         START / Repeated START pulse
//   o_stop          STOP pulse
//   o_hdr_restart   HDR Restart pattern complete pulse
//   o_hdr_exit      HDR Exit pattern (4th SDA fall) pulse
//   o_sda_fall_cnt  SDA falls in the current HDR pattern, saturates at 4
// -----------------------------------------------------------------------------
module bus_cond_detector #(
   parameter int unsigned FILT_LEN = 2
) (
   input  logic       i_sys_clk,
   input  logic       i_sys_rst,
   input  logic       i_scl,
   input  logic       i_sda,
   input  logic       i_hdr_en,
   output logic       o_scl,
   output logic       o_sda,
   output logic       o_scl_pos,
   output logic       o_scl_neg,
   output logic       o_sda_pos,
   output logic       o_sda_neg,
   output logic       o_start,
   output logic       o_stop,
   output logic       o_hdr_restart,
   output logic       o_hdr_exit,
   output logic [2:0] o_sda_fall_cnt
);

   localparam logic [3:0] LP_FILT_M1 = 4'(FILT_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COUNT,
      ST_RST_ARM,
      ST_DONE
   } state_t;

   // synchronizers
   logic r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
   // filters
   logic       r_scl_f, r_sda_f;
   logic [3:0] r_scl_cnt, r_sda_cnt;
   // previous-cycle filtered values
   logic       r_scl_d, r_sda_d;
   // registered pulses
   logic r_scl_pos, r_scl_neg, r_sda_pos, r_sda_neg;
   logic r_start, r_stop, r_hdr_restart, r_hdr_exit;
   // HDR FSM
   state_t     r_state, w_state_nxt;
   logic [2:0] r_fall_cnt, w_fall_cnt_nxt;
   logic       w_exit, w_restart;

   logic w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
   logic w_scl_hi, w_scl_lo, w_start, w_stop;

   // Synchronizer, filter and one-cycle delay of the filtered value.
   // Everything resets to 1 so that released lines look idle-high.
   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         r_scl_s1  <= 1'b1;
         r_scl_s2  <= 1'b1;
         r_sda_s1  <= 1'b1;
         r_sda_s2  <= 1'b1;
         r_scl_f   <= 1'b1;
         r_sda_f   <= 1'b1;
         r_scl_d   <= 1'b1;
         r_sda_d   <= 1'b1;
         r_scl_cnt <= '0;
         r_sda_cnt <= '0;
      end else begin
         r_scl_s1 <= i_scl;
         r_scl_s2 <= r_scl_s1;
         r_sda_s1 <= i_sda;
         r_sda_s2 <= r_sda_s1;
         r_scl_d  <= r_scl_f;
         r_sda_d  <= r_sda_f;

         if (r_scl_s2 != r_scl_f) begin
            if (r_scl_cnt == LP_FILT_M1) begin
               r_scl_f   <= r_scl_s2;
               r_scl_cnt <= '0;
            end else begin
               r_scl_cnt <= r_scl_cnt + 4'd1;
            end
         end else begin
            r_scl_cnt <= '0;
         end

         if (r_sda_s2 != r_sda_f) begin
            if (r_sda_cnt == LP_FILT_M1) begin
               r_sda_f   <= r_sda_s2;
               r_sda_cnt <= '0;
            end else begin
               r_sda_cnt <= r_sda_cnt + 4'd1;
            end
         end else begin
            r_sda_cnt <= '0;
         end
      end
   end

   // Events seen between the previous and current filtered values.
   assign w_scl_rise = r_scl_f & ~r_scl_d;
   assign w_scl_fall = ~r_scl_f & r_scl_d;
   assign w_sda_rise = r_sda_f & ~r_sda_d;
   assign w_sda_fall = ~r_sda_f & r_sda_d;
   // SCL level qualifiers require SCL to be steady across the event, so a
   // simultaneous SCL/SDA change never counts as START/STOP or an HDR step.
   assign w_scl_hi   = r_scl_f & r_scl_d;
   assign w_scl_lo   = ~r_scl_f & ~r_scl_d;
   assign w_start    = w_sda_fall & w_scl_hi;
   assign w_stop     = w_sda_rise & w_scl_hi;

   // HDR pattern next-state logic
   always_comb begin
      w_state_nxt    = r_state;
      w_fall_cnt_nxt = r_fall_cnt;
      w_exit         = 1'b0;
      w_restart      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_sda_fall && w_scl_lo) begin
               w_state_nxt    = ST_COUNT;
               w_fall_cnt_nxt = 3'd1;
            end
         end
         ST_COUNT: begin
            if (w_scl_rise) begin
               w_state_nxt    = ST_IDLE;
               w_fall_cnt_nxt = 3'd0;
            end else if (w_sda_fall && w_scl_lo) begin
               if (r_fall_cnt >= 3'd3) begin
                  w_state_nxt    = ST_DONE;
                  w_fall_cnt_nxt = 3'd4;
                  w_exit         = 1'b1;
               end else begin
                  w_fall_cnt_nxt = r_fall_cnt + 3'd1;
               end
            end else if (w_sda_rise && w_scl_lo && (r_fall_cnt == 3'd2)) begin
               w_state_nxt = ST_RST_ARM;
            end
         end
         ST_RST_ARM: begin
            if (w_scl_rise) begin
               // SCL rising with SDA low abandons the pattern silently.
               w_state_nxt    = ST_IDLE;
               w_fall_cnt_nxt = 3'd0;
               w_restart      = r_sda_f;
            end else if (w_sda_fall && w_scl_lo) begin
               w_state_nxt    = ST_COUNT;
               w_fall_cnt_nxt = 3'd3;
            end
         end
         ST_DONE: begin
            w_fall_cnt_nxt = 3'd4;
            if (w_stop) begin
               w_state_nxt    = ST_IDLE;
               w_fall_cnt_nxt = 3'd0;
            end
         end
         default: begin
            w_state_nxt    = ST_IDLE;
            w_fall_cnt_nxt = 3'd0;
         end
      endcase

      if (!i_hdr_en) begin
         w_state_nxt    = ST_IDLE;
         w_fall_cnt_nxt = 3'd0;
         w_exit         = 1'b0;
         w_restart      = 1'b0;
      end
   end

   // Pulse registers and FSM state
   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         r_scl_pos     <= 1'b0;
         r_scl_neg     <= 1'b0;
         r_sda_pos     <= 1'b0;
         r_sda_neg     <= 1'b0;
         r_start       <= 1'b0;
         r_stop        <= 1'b0;
         r_hdr_restart <= 1'b0;
         r_hdr_exit    <= 1'b0;
         r_state       <= ST_IDLE;
         r_fall_cnt    <= '0;
      end else begin
         r_scl_pos     <= w_scl_rise;
         r_scl_neg     <= w_scl_fall;
         r_sda_pos     <= w_sda_rise;
         r_sda_neg     <= w_sda_fall;
         r_start       <= w_start;
         r_stop        <= w_stop;
         r_hdr_restart <= w_restart;
         r_hdr_exit    <= w_exit;
         r_state       <= w_state_nxt;
         r_fall_cnt    <= w_fall_cnt_nxt;
      end
   end

   assign o_scl          = r_scl_f;
   assign o_sda          = r_sda_f;
   assign o_scl_pos      = r_scl_pos;
   assign o_scl_neg      = r_scl_neg;
   assign o_sda_pos      = r_sda_pos;
   assign o_sda_neg      = r_sda_neg;
   assign o_start        = r_start;
   assign o_stop         = r_stop;
   assign o_hdr_restart  = r_hdr_restart;
   assign o_hdr_exit     = r_hdr_exit;
   assign o_sda_fall_cnt = r_fall_cnt;

endmodule

// File: tb/tb_bus_cond_detector.sv
// -----------------------------------------------------------------------------
// tb_bus_cond_detector
// Directed stimulus for bus_cond_detector with a cycle-level reference model
// of the line filter, bus conditions and HDR pattern rules, checked against
// every output on each falling clock edge, plus literal expectations.
// -----------------------------------------------------------------------------
module tb_bus_cond_detector;

   localparam int FL = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1;
   logic       sda = 1'b1;
   logic       hdr = 1'b0;
   logic       o_scl, o_sda, o_scl_pos, o_scl_neg, o_sda_pos, o_sda_neg;
   logic       o_start, o_stop, o_hdr_restart, o_hdr_exit;
   logic [2:0] o_cnt;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   bus_cond_detector #(.FILT_LEN(FL)) dut (
      .i_sys_clk(clk), .i_sys_rst(rst), .i_scl(scl), .i_sda(sda),
      .i_hdr_en(hdr), .o_scl(o_scl), .o_sda(o_sda),
      .o_scl_pos(o_scl_pos), .o_scl_neg(o_scl_neg),
      .o_sda_pos(o_sda_pos), .o_sda_neg(o_sda_neg),
      .o_start(o_start), .o_stop(o_stop),
      .o_hdr_restart(o_hdr_restart), .o_hdr_exit(o_hdr_exit),
      .o_sda_fall_cnt(o_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // h_x[k] is the raw pad value sampled k edges ago (0 = this edge).
   logic [17:0] h_scl, h_sda;
   bit m_scl, m_sda, m_scl_o, m_sda_o;
   bit e_scl_pos, e_scl_neg, e_sda_pos, e_sda_neg;
   bit e_start, e_stop, e_restart, e_exit;
   int m_cnt;
   int m_ph;   // 0 idle, 1 counting, 2 restart armed, 3 done

   // A filtered line follows once the value it sees (two samples late) has
   // disagreed with it for FL consecutive cycles.
   function automatic bit filt_next(input logic [17:0] h, input bit f);
      for (int k = 2; k < FL + 2; k++)
         if (h[k] == f) return f;
      return ~f;
   endfunction

   always @(posedge clk or posedge rst) begin
      bit sr, sf, dr, df, hi, lo;
      if (rst) begin
         h_scl = '1; h_sda = '1;
         m_scl = 1; m_sda = 1; m_scl_o = 1; m_sda_o = 1;
         {e_scl_pos, e_scl_neg, e_sda_pos, e_sda_neg} = '0;
         {e_start, e_stop, e_restart, e_exit} = '0;
         m_cnt = 0; m_ph = 0;
      end else begin
         h_scl = {h_scl[16:0], scl};
         h_sda = {h_sda[16:0], sda};
         sr = m_scl & !m_scl_o;  sf = !m_scl & m_scl_o;
         dr = m_sda & !m_sda_o;  df = !m_sda & m_sda_o;
         hi = m_scl & m_scl_o;   lo = !m_scl & !m_scl_o;
         e_scl_pos = sr; e_scl_neg = sf; e_sda_pos = dr; e_sda_neg = df;
         e_start = df & hi;
         e_stop  = dr & hi;
         e_restart = 0; e_exit = 0;
         if (!hdr) begin
            m_ph = 0; m_cnt = 0;
         end else if (m_ph == 0) begin
            if (df && lo) begin m_ph = 1; m_cnt = 1; end
         end else if (m_ph == 1) begin
            if (sr) begin m_ph = 0; m_cnt = 0; end
            else if (df && lo) begin
               m_cnt = m_cnt + 1;
               if (m_cnt == 4) begin e_exit = 1; m_ph = 3; end
            end else if (dr && lo && m_cnt == 2) m_ph = 2;
         end else if (m_ph == 2) begin
            if (sr) begin e_restart = m_sda; m_ph = 0; m_cnt = 0; end
            else if (df && lo) begin m_ph = 1; m_cnt = 3; end
         end else begin
            if (e_stop) begin m_ph = 0; m_cnt = 0; end
         end
         m_scl_o = m_scl; m_sda_o = m_sda;
         m_scl = filt_next(h_scl, m_scl);
         m_sda = filt_next(h_sda, m_sda);
      end
   end

   // ---------------- compare + pulse monitors ----------------
   int n_start, n_stop, n_restart, n_exit, n_sda_neg, n_edges, min_sda;
   int start_cyc, neg_cyc;

   always @(negedge clk) begin
      chk("o_scl", o_scl, m_scl);
      chk("o_sda", o_sda, m_sda);
      chk("o_scl_pos", o_scl_pos, e_scl_pos);
      chk("o_scl_neg", o_scl_neg, e_scl_neg);
      chk("o_sda_pos", o_sda_pos, e_sda_pos);
      chk("o_sda_neg", o_sda_neg, e_sda_neg);
      chk("o_start", o_start, e_start);
      chk("o_stop", o_stop, e_stop);
      chk("o_hdr_restart", o_hdr_restart, e_restart);
      chk("o_hdr_exit", o_hdr_exit, e_exit);
      chk("o_sda_fall_cnt", o_cnt, m_cnt);
      n_start   += o_start;
      n_stop    += o_stop;
      n_restart += o_hdr_restart;
      n_exit    += o_hdr_exit;
      n_sda_neg += o_sda_neg;
      n_edges   += o_scl_pos + o_scl_neg + o_sda_pos + o_sda_neg;
      if (o_sda < min_sda) min_sda = o_sda;
      if (o_start && start_cyc < 0) start_cyc = cyc;
      if (o_sda_neg && neg_cyc < 0) neg_cyc = cyc;
   end

   task automatic clr();
      n_start = 0; n_stop = 0; n_restart = 0; n_exit = 0;
      n_sda_neg = 0; n_edges = 0; min_sda = 1;
      start_cyc = -1; neg_cyc = -1;
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // SDA toggles with SCL held low: `falls` falls, leaving SDA low.
   task automatic sda_falls(input int falls);
      for (int i = 0; i < falls; i++) begin
         sda = 1'b0; hold(8);
         if (i < falls - 1) begin sda = 1'b1; hold(8); end
      end
   endtask

   initial begin
      int m;
      clr();
      hold(3);
      chk("rst_o_scl", o_scl, 1);
      chk("rst_o_sda", o_sda, 1);
      chk("rst_cnt", o_cnt, 0);
      chk("rst_start", o_start, 0);
      rst = 1'b0;
      hold(6);

      // START latency with SCL high
      clr();
      m = cyc;
      sda = 1'b0;
      hold(8);
      chk("start_count", n_start, 1);
      chk("sda_neg_count", n_sda_neg, 1);
      chk("start_latency", start_cyc - m, 5);
      chk("sda_neg_latency", neg_cyc - m, 5);
      clr();
      sda = 1'b1;
      hold(8);
      chk("stop_count", n_stop, 1);

      // one-cycle low glitch is filtered out
      clr();
      sda = 1'b0; hold(1);
      sda = 1'b1; hold(8);
      chk("glitch_edges", n_edges, 0);
      chk("glitch_start", n_start, 0);
      chk("glitch_o_sda_min", min_sda, 1);

      // HDR Exit: four falls with SCL low
      hdr = 1'b1;
      scl = 1'b0; hold(8);
      clr();
      for (int i = 0; i < 4; i++) begin
         sda = 1'b0; hold(8);
         chk("exit_cnt_step", o_cnt, i + 1);
         if (i < 3) begin sda = 1'b1; hold(8); end
      end
      chk("exit_pulses", n_exit, 1);
      scl = 1'b1; hold(8);
      chk("exit_cnt_hold", o_cnt, 4);
      clr();
      sda = 1'b1; hold(8);
      chk("exit_stop", n_stop, 1);
      chk("exit_cnt_idle", o_cnt, 0);

      // HDR Restart: two falls, SDA rise, SCL rise
      scl = 1'b0; hold(8);
      clr();
      sda_falls(2);
      sda = 1'b1; hold(8);
      scl = 1'b1; hold(8);
      chk("restart_pulses", n_restart, 1);
      chk("restart_no_exit", n_exit, 0);
      chk("restart_cnt", o_cnt, 0);

      // three falls then SCL rise abandons the pattern
      scl = 1'b0; hold(8);
      clr();
      sda_falls(3);
      chk("three_cnt", o_cnt, 3);
      scl = 1'b1; hold(8);
      chk("three_cnt_after", o_cnt, 0);
      chk("three_no_pulse", n_restart + n_exit, 0);
      sda = 1'b1; hold(8);

      // HDR mode dropped mid-pattern
      scl = 1'b0; hold(8);
      clr();
      sda_falls(2);
      chk("drop_cnt_before", o_cnt, 2);
      hdr = 1'b0; hold(2);
      chk("drop_cnt", o_cnt, 0);
      sda = 1'b1; hold(8);
      scl = 1'b1; hold(8);
      chk("drop_no_pulse", n_restart + n_exit, 0);
      hdr = 1'b1; hold(4);

      // reset mid-pattern, released with pads low
      scl = 1'b0; hold(8);
      sda_falls(3);
      chk("rstmid_cnt_before", o_cnt, 3);
      rst = 1'b1; hold(4);
      chk("rstmid_o_scl", o_scl, 1);
      chk("rstmid_o_sda", o_sda, 1);
      chk("rstmid_cnt", o_cnt, 0);
      clr();
      rst = 1'b0; hold(3);
      chk("release_quiet", n_edges + n_start + n_stop, 0);
      chk("release_o_sda", o_sda, 1);
      hold(8);
      chk("release_o_sda_low", o_sda, 0);
      chk("release_no_cond", n_start + n_stop + n_exit, 0);
      chk("release_cnt", o_cnt, 0);
      clr();
      sda = 1'b1; hold(8);
      sda_falls(4);
      chk("rstmid_exit", n_exit, 1);
      chk("rstmid_cnt_final", o_cnt, 4);

      hold(4);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
